// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared defaults and segment-bound helpers for pipe_adder
package pipe_adder_pkg;

   localparam int DATA_WIDTH_DEF = 3;
   localparam int NUM_REG_DEF    = 2;

   // Width of every segment except possibly the last (ceil division)
   function automatic int seg_w(input int dw, input int nr);
      return (dw + nr - 1) / nr;
   endfunction

   // Lowest operand bit covered by segment i; >= dw means the segment is empty
   function automatic int seg_lo(input int i, input int dw, input int nr);
      return i * seg_w(dw, nr);
   endfunction

   // Highest operand bit covered by segment i, clipped to the operand width
   function automatic int seg_hi(input int i, input int dw, input int nr);
      int hi;
      hi = (i + 1) * seg_w(dw, nr);
      if (hi > dw) hi = dw;
      return hi - 1;
   endfunction

endpackage

// File: rtl/adder_segment.sv
// rtl/adder_segment.sv - one registered carry-chained slice of the pipelined adder
module adder_segment
   import pipe_adder_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   // Register the slice sum together with its carry-out for the next segment
   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
      end else begin
         {cout, sum} <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      end
   end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - segmented, fully registered unsigned adder with NUM_REG latency
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int INP_DW  = DATA_WIDTH_DEF,
   parameter int NUM_REG = NUM_REG_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INP_DW-1:0] inp1,
   input  logic [INP_DW-1:0] inp2,
   output logic [INP_DW:0]   outp
);

   // carry[i] is the registered carry leaving stage i; sum_bus collects aligned slices
   logic [NUM_REG-1:0] carry;
   logic [INP_DW-1:0]  sum_bus;

   for (genvar i = 0; i < NUM_REG; i++) begin : g_stage
      localparam int LO  = seg_lo(i, INP_DW, NUM_REG);
      localparam int HI  = seg_hi(i, INP_DW, NUM_REG);
      localparam int DSK = NUM_REG - 1 - i;

      if (LO < INP_DW) begin : g_add
         localparam int W = HI - LO + 1;

         logic [W-1:0] a_seg;
         logic [W-1:0] b_seg;
         logic [W-1:0] s_seg;
         logic         cin;
         logic         cout;

         if (i == 0) begin : g_cin_zero
            assign cin = 1'b0;
         end else begin : g_cin_chain
            assign cin = carry[i-1];
         end

         if (i == 0) begin : g_no_skew
            assign a_seg = inp1[HI:LO];
            assign b_seg = inp2[HI:LO];
         end else begin : g_skew
            logic [W-1:0] a_sk [i];
            logic [W-1:0] b_sk [i];

            // Hold this slice back i cycles so it meets the carry from the stage below
            always_ff @(posedge clk) begin
               if (rst) begin
                  for (int k = 0; k < i; k++) begin
                     a_sk[k] <= '0;
                     b_sk[k] <= '0;
                  end
               end else begin
                  a_sk[0] <= inp1[HI:LO];
                  b_sk[0] <= inp2[HI:LO];
                  for (int k = 1; k < i; k++) begin
                     a_sk[k] <= a_sk[k-1];
                     b_sk[k] <= b_sk[k-1];
                  end
               end
            end

            assign a_seg = a_sk[i-1];
            assign b_seg = b_sk[i-1];
         end

         adder_segment #(.W(W)) u_seg (
            .clk  (clk),
            .rst  (rst),
            .a    (a_seg),
            .b    (b_seg),
            .cin  (cin),
            .sum  (s_seg),
            .cout (cout)
         );

         assign carry[i] = cout;

         if (DSK == 0) begin : g_no_deskew
            assign sum_bus[HI:LO] = s_seg;
         end else begin : g_deskew
            logic [W-1:0] s_dk [DSK];

            // Delay the finished slice until the upper slices catch up
            always_ff @(posedge clk) begin
               if (rst) begin
                  for (int k = 0; k < DSK; k++) begin
                     s_dk[k] <= '0;
                  end
               end else begin
                  s_dk[0] <= s_seg;
                  for (int k = 1; k < DSK; k++) begin
                     s_dk[k] <= s_dk[k-1];
                  end
               end
            end

            assign sum_bus[HI:LO] = s_dk[DSK-1];
         end
      end else begin : g_delay
         logic c_q;

         // Empty segment: only forward the carry so latency stays NUM_REG
         always_ff @(posedge clk) begin
            if (rst) begin
               c_q <= 1'b0;
            end else begin
               c_q <= carry[i-1];
            end
         end

         assign carry[i] = c_q;
      end
   end

   assign outp = {carry[NUM_REG-1], sum_bus};

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - directed and sweep checks of pipe_adder across several configurations
module tb_pipe_adder;

   logic       tb_clk;
   logic       rst;
   logic [2:0] a3, b3;
   logic [3:0] a4, b4;
   logic [7:0] a8, b8;
   logic [3:0] o32, o31, o33;
   logic [4:0] o43;
   logic [8:0] o83;

   int n_cmp;
   int n_err;
   bit sb_on;

   int m32 [2];
   int m31 [1];
   int m33 [3];
   int m43 [3];
   int m83 [3];

   pipe_adder #(.INP_DW(3), .NUM_REG(2)) dut (
      .clk(tb_clk), .rst(rst), .inp1(a3), .inp2(b3), .outp(o32));
   pipe_adder #(.INP_DW(3), .NUM_REG(1)) dut_r1 (
      .clk(tb_clk), .rst(rst), .inp1(a3), .inp2(b3), .outp(o31));
   pipe_adder #(.INP_DW(3), .NUM_REG(3)) dut_r3 (
      .clk(tb_clk), .rst(rst), .inp1(a3), .inp2(b3), .outp(o33));
   pipe_adder #(.INP_DW(4), .NUM_REG(3)) dut_w4 (
      .clk(tb_clk), .rst(rst), .inp1(a4), .inp2(b4), .outp(o43));
   pipe_adder #(.INP_DW(8), .NUM_REG(3)) dut_w8 (
      .clk(tb_clk), .rst(rst), .inp1(a8), .inp2(b8), .outp(o83));

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Golden model: exact sum delayed NUM_REG edges, cleared by reset
   task automatic tick();
      if (rst) begin
         foreach (m32[k]) m32[k] = 0;
         foreach (m31[k]) m31[k] = 0;
         foreach (m33[k]) m33[k] = 0;
         foreach (m43[k]) m43[k] = 0;
         foreach (m83[k]) m83[k] = 0;
      end else begin
         for (int k = 1; k > 0; k--) m32[k] = m32[k-1];
         for (int k = 2; k > 0; k--) m33[k] = m33[k-1];
         for (int k = 2; k > 0; k--) m43[k] = m43[k-1];
         for (int k = 2; k > 0; k--) m83[k] = m83[k-1];
         m32[0] = int'(a3) + int'(b3);
         m31[0] = int'(a3) + int'(b3);
         m33[0] = int'(a3) + int'(b3);
         m43[0] = int'(a4) + int'(b4);
         m83[0] = int'(a8) + int'(b8);
      end
      @(posedge tb_clk);
      #1;
      if (sb_on) begin
         check("sweep_w3_r2", int'(o32), m32[1]);
         check("sweep_w3_r1", int'(o31), m31[0]);
         check("sweep_w3_r3", int'(o33), m33[2]);
         check("sweep_w4_r3", int'(o43), m43[2]);
         check("sweep_w8_r3", int'(o83), m83[2]);
      end
   endtask

   initial begin
      int a;
      int b;
      n_cmp = 0;
      n_err = 0;
      sb_on = 1'b0;
      foreach (m32[k]) m32[k] = 0;
      foreach (m31[k]) m31[k] = 0;
      foreach (m33[k]) m33[k] = 0;
      foreach (m43[k]) m43[k] = 0;
      foreach (m83[k]) m83[k] = 0;
      rst = 1'b1;
      a3 = 3'd5; b3 = 3'd6;
      a4 = '0; b4 = '0;
      a8 = '0; b8 = '0;

      // Reset held two edges with live operands
      tick(); check("rst_hold_1", int'(o32), 0);
      tick(); check("rst_hold_2", int'(o32), 0);
      rst = 1'b0;
      tick(); check("rst_first_edge", int'(o32), 0);
      tick(); check("rst_release_sum", int'(o32), 11);

      // Carry from bits [1:0] into bit 2, exactly two edges later
      a3 = 3'd3; b3 = 3'd1;
      tick(); check("carry_prev_result", int'(o32), 11);
      a3 = 3'd0; b3 = 3'd0;
      tick(); check("carry_boundary", int'(o32), 4);

      // Extremes
      a3 = 3'd7; b3 = 3'd7;
      tick(); check("zero_plus_zero", int'(o32), 0);
      a3 = 3'd7; b3 = 3'd0;
      tick(); check("max_operands", int'(o32), 14);
      a3 = 3'd0; b3 = 3'd0;
      tick(); check("seven_plus_zero", int'(o32), 7);

      // Back-to-back stream, no bubbles
      a3 = 3'd1; b3 = 3'd2;
      tick(); check("stream_lead", int'(o32), 0);
      a3 = 3'd7; b3 = 3'd7;
      tick(); check("stream_0", int'(o32), 3);
      a3 = 3'd4; b3 = 3'd4;
      tick(); check("stream_1", int'(o32), 14);
      a3 = 3'd6; b3 = 3'd3;
      tick(); check("stream_2", int'(o32), 8);
      a3 = 3'd0; b3 = 3'd0;
      tick(); check("stream_3", int'(o32), 9);

      // Reset while (7,7) is in flight
      a3 = 3'd7; b3 = 3'd7;
      tick(); check("midrst_before", int'(o32), 0);
      rst = 1'b1;
      a3 = 3'd2; b3 = 3'd3;
      tick(); check("midrst_clear", int'(o32), 0);
      rst = 1'b0;
      tick(); check("midrst_no_stale", int'(o32), 0);
      a3 = 3'd0; b3 = 3'd0;
      tick(); check("midrst_recover", int'(o32), 5);

      // Exhaustive 3-bit sweep, wider configs driven from the same index
      sb_on = 1'b1;
      for (int k = 0; k < 64; k++) begin
         a = k >> 3;
         b = k & 7;
         a3 = 3'(a);
         b3 = 3'(b);
         a4 = 4'((a << 1) | (b & 1));
         b4 = 4'((b << 1) | (a & 1));
         a8 = 8'(a * 36 + ((b == 7) ? 3 : 0));
         b8 = 8'(b * 36 + ((a == 7) ? 3 : 0));
         tick();
      end
      a3 = '0; b3 = '0;
      a4 = '0; b4 = '0;
      a8 = '0; b8 = '0;
      for (int k = 0; k < 3; k++) tick();
      sb_on = 1'b0;

      // Full-scale 8-bit pair through the three-stage pipe
      a8 = 8'd255; b8 = 8'd255;
      tick();
      a8 = '0; b8 = '0;
      tick();
      tick(); check("w8_max_sum", int'(o83), 510);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parameterised unsigned adder, split into carry-chained segments with a register after each segment.
- Accepts one operand pair per clock and produces the full-width sum (including carry-out) a fixed number of cycles later.
- Sits between a stimulus/master block that drives two operand buses and a consumer of the INP_DW+1-bit sum.
- Has no handshake; data is valid every cycle.

Parameters:
- INP_DW, 3, operand width in bits; legal range 1 or more.
- NUM_REG, 2, number of pipeline register stages and carry segments; legal range 1 to INP_DW. Latency equals NUM_REG.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inp1  input  INP_DW  operand A, unsigned.
- inp2  input  INP_DW  operand B, unsigned.
- outp  output  INP_DW+1  registered sum inp1+inp2; the MSB is the carry-out.

Behaviour:
- Segmentation:
  - SEG_W = ceil(INP_DW/NUM_REG).
  - Segment i (i=0..NUM_REG-1) covers operand bits [i*SEG_W, min((i+1)*SEG_W, INP_DW)-1].
  - The last segment may be narrower. Any segment whose range is empty is a pure delay stage.
- Stage i adds its operand slice plus the carry registered by stage i-1. Stage 0 has carry-in 0.
- Stage i registers three things: its sum slice, its carry-out, and every not-yet-added operand slice (input skew).
- Result slices already produced are delayed through per-stage registers so all slices align at the final stage (output deskew).
- outp is driven only by registers; there is no combinational path from inputs to outp.
- Latency:
  - Operands present at rising edge n appear on outp immediately after edge n+NUM_REG-1.
  - With NUM_REG=1 this is a single registered adder.
- Throughput: one result per clock. Consecutive operand pairs never interfere.
- Width rule: outp = zero-extended inp1 + zero-extended inp2, exact. There is no overflow; max outp = 2^(INP_DW+1)-2.
- Reset:
  - When rst is 1 at a rising edge, every pipeline register (sums, carries, skew, deskew) clears to 0.
  - outp reads 0 after that edge.
  - While rst is held, inputs are ignored.
  - After rst deasserts, the first valid result appears NUM_REG-1 edges after the first non-reset edge. Until then outp shows 0, since cleared stages add 0+0.
- Reset mid-operation discards all in-flight sums. There is no partial result; outp shows 0 until new data propagates.
- Inputs are X-free by contract. No internal checks.

Decomposition:
- Shared package pipe_adder_pkg:
  - function seg_w(INP_DW, NUM_REG) implementing the ceil division.
  - function seg_lo(i) / seg_hi(i) computing slice bounds.
  - constant defaults DATA_WIDTH_DEF=3, NUM_REG_DEF=2.
- One sub-module, adder_segment:
  - Parameter W.
  - Inputs a, b, cin, plus clk and rst.
  - Registered outputs sum[W-1:0] and cout.
  - Instantiated NUM_REG times in a generate loop.
- Skew and deskew shift registers live in the top level as generate-built register arrays.

Test Plan (INP_DW=3, NUM_REG=2 unless stated):
- Reset: hold rst=1 for 2 cycles with inp1=5, inp2=6 -> outp=0 during reset and for the first edge after; outp=11 on the second edge after rst falls.
- Carry across segment boundary: inp1=3, inp2=1 (carry from bits[1:0] into bit 2) -> outp=4 exactly 2 edges later.
- Max operands: inp1=7, inp2=7 -> outp=14 (4'b1110). Also 0+0 -> 0 and 7+0 -> 7.
- Back-to-back stream: apply (1,2),(7,7),(4,4),(6,3) on consecutive edges -> outp sequence 3,14,8,9 on consecutive edges starting at latency 2, with no bubbles.
- Reset mid-stream: assert rst for one edge while (7,7) is in flight -> outp=0 after that edge; the (7,7) result never appears; the next operands applied after reset yield the correct sum.
- Exhaustive sweep: all 64 pairs for each configuration (INP_DW=3, NUM_REG=1,2,3) and (INP_DW=8, NUM_REG=3) -> scoreboard compares outp with a golden a+b delayed NUM_REG cycles, zero mismatches.
